// File: rtl/cam_line_fill_ctrl_pkg.sv
// Shared widths, FSM encoding and tag helper for the data-cache miss-side line filler.
package cam_line_fill_ctrl_pkg;

    localparam int AddrWidth     = 32;
    localparam int WordSelWidth  = 2;
    localparam int ByteSelWidth  = 2;
    localparam int EntryNumWidth = 4;
    localparam int TagWidth      = AddrWidth - WordSelWidth - ByteSelWidth;
    localparam int DataWidth     = 32;
    localparam int WordsPerLine  = 1 << WordSelWidth;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_REQ  = 3'd1,
        FILL_BEAT = 3'd2,
        CAM_WRITE = 3'd3,
        DONE      = 3'd4
    } fill_state_e;

    function automatic logic [TagWidth-1:0] addrTag(input logic [AddrWidth-1:0] addr);
        return addr[AddrWidth-1 -: TagWidth];
    endfunction

endpackage

// File: rtl/cam_line_fill_ctrl_if.sv
// Bundles the LSU request, tag CAM, memory bus and data array signals of the line filler.
interface cam_line_fill_ctrl_if;
    import cam_line_fill_ctrl_pkg::*;

    logic                     in_ReqValid;
    logic [AddrWidth-1:0]     in_ReqAddr;
    logic                     in_CAMMatchUp;
    logic [TagWidth-1:0]      out_CAMInput;
    logic [EntryNumWidth-1:0] out_CAMWriteEntry;
    logic                     out_CAMWriteEnable;
    logic                     out_Stall;
    logic                     out_MemReq;
    logic [AddrWidth-1:0]     out_MemAddr;
    logic                     in_MemAck;
    logic                     in_MemDataValid;
    logic [DataWidth-1:0]     in_MemData;
    logic                     out_DataWriteEnable;
    logic [EntryNumWidth-1:0] out_DataWriteEntry;
    logic [WordSelWidth-1:0]  out_DataWriteWord;
    logic [DataWidth-1:0]     out_DataWriteData;

    modport master (
        input  in_ReqValid, in_ReqAddr, in_CAMMatchUp, in_MemAck, in_MemDataValid, in_MemData,
        output out_CAMInput, out_CAMWriteEntry, out_CAMWriteEnable, out_Stall, out_MemReq,
               out_MemAddr, out_DataWriteEnable, out_DataWriteEntry, out_DataWriteWord,
               out_DataWriteData
    );

    modport slave (
        output in_ReqValid, in_ReqAddr, in_CAMMatchUp, in_MemAck, in_MemDataValid, in_MemData,
        input  out_CAMInput, out_CAMWriteEntry, out_CAMWriteEnable, out_Stall, out_MemReq,
               out_MemAddr, out_DataWriteEnable, out_DataWriteEntry, out_DataWriteWord,
               out_DataWriteData
    );

endinterface

// File: rtl/cam_line_fill_ctrl_victim_ptr.sv
// Round-robin victim pointer: advances once per completed fill, wrapping at 2^EntryNumWidth.
module cam_victim_ptr
    import cam_line_fill_ctrl_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_Advance,
    output logic [EntryNumWidth-1:0] o_Ptr
);

    logic [EntryNumWidth-1:0] r_Ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_Ptr <= '0;
        end else if (i_Advance) begin
            r_Ptr <= r_Ptr + EntryNumWidth'(1);
        end
    end

    assign o_Ptr = r_Ptr;

endmodule

// File: rtl/cam_line_fill_ctrl.sv
// Miss-side line filler for the tag CAM: request line, stream words, then publish the tag.
// Optional CAM_FILL_CRITICAL_WORD_FIRST_EN starts the burst at the requested word.
module cam_line_fill_ctrl
    import cam_line_fill_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    cam_line_fill_ctrl_if.master bus
);

    fill_state_e              r_State;
    fill_state_e              w_NextState;
    logic [TagWidth-1:0]      r_Tag;
    logic [WordSelWidth-1:0]  r_StartWord;
    logic [WordSelWidth-1:0]  r_BeatCnt;
    logic [TagWidth-1:0]      w_ReqTag;
    logic [WordSelWidth-1:0]  w_StartWord;
    logic                     w_Miss;
    logic                     w_Advance;
    logic [EntryNumWidth-1:0] w_Victim;

    assign w_ReqTag = addrTag(bus.in_ReqAddr);
    assign w_Miss   = bus.in_ReqValid && !bus.in_CAMMatchUp;

`ifdef CAM_FILL_CRITICAL_WORD_FIRST_EN
    assign w_StartWord = bus.in_ReqAddr[WordSelWidth+ByteSelWidth-1:ByteSelWidth];
`else
    assign w_StartWord = '0;
`endif

    cam_victim_ptr u_VictimPtr (
        .clock     (clock),
        .reset     (reset),
        .i_Advance (w_Advance),
        .o_Ptr     (w_Victim)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_State     <= IDLE;
            r_Tag       <= '0;
            r_StartWord <= '0;
            r_BeatCnt   <= '0;
        end else begin
            r_State <= w_NextState;
            case (r_State)
                IDLE: begin
                    if (w_Miss) begin
                        r_Tag       <= w_ReqTag;
                        r_StartWord <= w_StartWord;
                    end
                end
                FILL_REQ: begin
                    if (bus.in_MemAck) r_BeatCnt <= '0;
                end
                FILL_BEAT: begin
                    if (bus.in_MemDataValid) r_BeatCnt <= r_BeatCnt + WordSelWidth'(1);
                end
                default: ;
            endcase
        end
    end

    // Reset low forces idle outputs in the same cycle so an aborted fill never writes anything.
    always_comb begin
        w_NextState             = r_State;
        w_Advance               = 1'b0;
        bus.out_CAMInput        = (r_State == IDLE) ? w_ReqTag : r_Tag;
        bus.out_CAMWriteEntry   = w_Victim;
        bus.out_CAMWriteEnable  = 1'b0;
        bus.out_Stall           = 1'b0;
        bus.out_MemReq          = 1'b0;
        bus.out_MemAddr         = '0;
        bus.out_DataWriteEnable = 1'b0;
        bus.out_DataWriteEntry  = '0;
        bus.out_DataWriteWord   = '0;
        bus.out_DataWriteData   = '0;

        if (!reset) begin
            w_NextState      = IDLE;
            bus.out_CAMInput = w_ReqTag;
        end else begin
            case (r_State)
                IDLE: begin
                    if (w_Miss) begin
                        bus.out_Stall = 1'b1;
                        w_NextState   = FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    bus.out_Stall   = 1'b1;
                    bus.out_MemReq  = 1'b1;
                    bus.out_MemAddr = {r_Tag, r_StartWord, {ByteSelWidth{1'b0}}};
                    if (bus.in_MemAck) w_NextState = FILL_BEAT;
                end
                FILL_BEAT: begin
                    bus.out_Stall = 1'b1;
                    if (bus.in_MemDataValid) begin
                        bus.out_DataWriteEnable = 1'b1;
                        bus.out_DataWriteEntry  = w_Victim;
                        bus.out_DataWriteWord   = r_StartWord + r_BeatCnt;
                        bus.out_DataWriteData   = bus.in_MemData;
                        if (r_BeatCnt == WordSelWidth'(WordsPerLine - 1)) w_NextState = CAM_WRITE;
                    end
                end
                CAM_WRITE: begin
                    bus.out_Stall          = 1'b1;
                    bus.out_CAMWriteEnable = 1'b1;
                    w_Advance              = 1'b1;
                    w_NextState            = DONE;
                end
                DONE: begin
                    w_NextState = IDLE;
                end
                default: begin
                    w_NextState = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_line_fill_ctrl.sv
// Directed, table-driven bench for cam_line_fill_ctrl plus multi-cycle corner sequences.
module tb_cam_line_fill_ctrl;
    import cam_line_fill_ctrl_pkg::*;

    typedef struct {
        logic        rstN;
        logic        reqValid;
        logic [31:0] reqAddr;
        logic        camMatch;
        logic        memAck;
        logic        memValid;
        logic [31:0] memData;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        memReq;
        logic [31:0] memAddr;
        logic        dwe;
        logic [3:0]  dEntry;
        logic [1:0]  dWord;
        logic [31:0] dData;
        logic        cwe;
        logic [3:0]  cEntry;
        logic [27:0] camIn;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;

    always #5 clock = ~clock;

    cam_line_fill_ctrl_if busIf ();

    cam_line_fill_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf.master)
    );

    function automatic logic [1:0] startOf(input logic [31:0] addr);
`ifdef CAM_FILL_CRITICAL_WORD_FIRST_EN
        return addr[3:2];
`else
        return 2'(addr[0] & 1'b0);
`endif
    endfunction

    function automatic logic [31:0] lineAddr(input logic [31:0] addr);
        return {addr[31:4], startOf(addr), 2'b00};
    endfunction

    function automatic stim_t mkStim(input logic rstN, input logic reqValid, input logic [31:0] addr,
                                     input logic match, input logic ack, input logic valid,
                                     input logic [31:0] data);
        stim_t s;
        s.rstN = rstN; s.reqValid = reqValid; s.reqAddr = addr; s.camMatch = match;
        s.memAck = ack; s.memValid = valid; s.memData = data;
        return s;
    endfunction

    function automatic exp_t mkExp(input logic stall, input logic memReq, input logic [31:0] memAddr,
                                   input logic dwe, input logic [3:0] dEntry, input logic [1:0] dWord,
                                   input logic [31:0] dData, input logic cwe, input logic [3:0] cEntry,
                                   input logic [27:0] camIn);
        exp_t e;
        e.stall = stall; e.memReq = memReq; e.memAddr = memAddr; e.dwe = dwe; e.dEntry = dEntry;
        e.dWord = dWord; e.dData = dData; e.cwe = cwe; e.cEntry = cEntry; e.camIn = camIn;
        return e;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic applyStimulus(input stim_t s);
        @(negedge clock);
        reset                 = s.rstN;
        busIf.in_ReqValid     = s.reqValid;
        busIf.in_ReqAddr      = s.reqAddr;
        busIf.in_CAMMatchUp   = s.camMatch;
        busIf.in_MemAck       = s.memAck;
        busIf.in_MemDataValid = s.memValid;
        busIf.in_MemData      = s.memData;
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        checkVal({tag, " stall"},  32'(busIf.out_Stall),           32'(e.stall));
        checkVal({tag, " memReq"}, 32'(busIf.out_MemReq),          32'(e.memReq));
        checkVal({tag, " memAddr"}, busIf.out_MemAddr,             e.memAddr);
        checkVal({tag, " dwe"},    32'(busIf.out_DataWriteEnable), 32'(e.dwe));
        checkVal({tag, " dEntry"}, 32'(busIf.out_DataWriteEntry),  32'(e.dEntry));
        checkVal({tag, " dWord"},  32'(busIf.out_DataWriteWord),   32'(e.dWord));
        checkVal({tag, " dData"},  busIf.out_DataWriteData,        e.dData);
        checkVal({tag, " cwe"},    32'(busIf.out_CAMWriteEnable),  32'(e.cwe));
        checkVal({tag, " cEntry"}, 32'(busIf.out_CAMWriteEntry),   32'(e.cEntry));
        checkVal({tag, " camIn"},  32'(busIf.out_CAMInput),        32'(e.camIn));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[13];
        logic [31:0] addrA;
        logic [27:0] tagA;
        logic [31:0] memA;
        logic        pat[7];
        int          benchWrites;
        int          dutWrites;

        reset                 = 1'b0;
        busIf.in_ReqValid     = 1'b0;
        busIf.in_ReqAddr      = '0;
        busIf.in_CAMMatchUp   = 1'b0;
        busIf.in_MemAck       = 1'b0;
        busIf.in_MemDataValid = 1'b0;
        busIf.in_MemData      = '0;

        addrA = 32'h0000_1238;
        tagA  = 28'h000_0123;
        memA  = lineAddr(addrA);

        // Hit, then a miss with late ack and four back-to-back beats into entry 0.
        vecs[0]  = '{mkStim(0, 0, 32'h0, 0, 0, 0, 0),       mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 28'h0)};
        vecs[1]  = '{mkStim(1, 1, 32'h1234, 1, 0, 0, 0),    mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, tagA)};
        vecs[2]  = '{mkStim(1, 1, addrA, 0, 0, 0, 0),       mkExp(1, 0, 0, 0, 0, 0, 0, 0, 0, tagA)};
        vecs[3]  = '{mkStim(1, 1, addrA, 0, 0, 0, 0),       mkExp(1, 1, memA, 0, 0, 0, 0, 0, 0, tagA)};
        vecs[4]  = '{mkStim(1, 1, addrA, 0, 0, 0, 0),       mkExp(1, 1, memA, 0, 0, 0, 0, 0, 0, tagA)};
        vecs[5]  = '{mkStim(1, 1, addrA, 0, 1, 0, 0),       mkExp(1, 1, memA, 0, 0, 0, 0, 0, 0, tagA)};
        for (int k = 0; k < 4; k++) begin
            vecs[6+k] = '{mkStim(1, 1, addrA, 0, 0, 1, 32'hA0 + 32'(k)),
                          mkExp(1, 0, 0, 1, 0, startOf(addrA) + 2'(k), 32'hA0 + 32'(k), 0, 0, tagA)};
        end
        vecs[10] = '{mkStim(1, 1, addrA, 0, 0, 0, 0),       mkExp(1, 0, 0, 0, 0, 0, 0, 1, 0, tagA)};
        vecs[11] = '{mkStim(1, 1, addrA, 1, 0, 0, 0),       mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, tagA)};
        vecs[12] = '{mkStim(1, 1, addrA, 1, 0, 0, 0),       mkExp(0, 0, 0, 0, 0, 0, 0, 0, 1, tagA)};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].e, $sformatf("v%0d", i));
        end

        // Gapped beats with the request address changing mid-fill; victim is entry 1.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        applyStimulus(mkStim(1, 1, 32'h0000_4448, 0, 0, 0, 0));
        checkVal("gap miss stall", 32'(busIf.out_Stall), 32'd1);
        applyStimulus(mkStim(1, 1, 32'hDEAD_BEEC, 0, 0, 1, 32'hFF));
        checkVal("gap req memReq", 32'(busIf.out_MemReq), 32'd1);
        checkVal("gap req memAddr", busIf.out_MemAddr, lineAddr(32'h0000_4448));
        checkVal("gap req early valid dwe", 32'(busIf.out_DataWriteEnable), 32'd0);
        checkVal("gap req camIn", 32'(busIf.out_CAMInput), 32'h000_0444);
        applyStimulus(mkStim(1, 1, 32'hDEAD_BEEC, 0, 1, 0, 0));
        checkVal("gap ack memReq", 32'(busIf.out_MemReq), 32'd1);
        benchWrites = 0;
        dutWrites   = 0;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(mkStim(1, 1, 32'hDEAD_BEEC, 0, 0, pat[k], 32'hB0 + 32'(k)));
            checkVal($sformatf("gap beat%0d dwe", k), 32'(busIf.out_DataWriteEnable), 32'(pat[k]));
            checkVal($sformatf("gap beat%0d cwe", k), 32'(busIf.out_CAMWriteEnable), 32'd0);
            if (busIf.out_DataWriteEnable) dutWrites++;
            if (pat[k]) begin
                checkVal($sformatf("gap beat%0d dWord", k), 32'(busIf.out_DataWriteWord),
                         32'(startOf(32'h0000_4448) + 2'(benchWrites)));
                checkVal($sformatf("gap beat%0d dEntry", k), 32'(busIf.out_DataWriteEntry), 32'd1);
                benchWrites++;
            end
        end
        checkVal("gap write count", 32'(dutWrites), 32'd4);
        applyStimulus(mkStim(1, 1, 32'hDEAD_BEEC, 0, 0, 0, 0));
        checkVal("gap cwe", 32'(busIf.out_CAMWriteEnable), 32'd1);
        checkVal("gap cEntry", 32'(busIf.out_CAMWriteEntry), 32'd1);
        checkVal("gap latched tag", 32'(busIf.out_CAMInput), 32'h000_0444);
        applyStimulus(mkStim(1, 1, 32'hDEAD_BEEC, 1, 0, 0, 0));
        checkVal("gap done stall", 32'(busIf.out_Stall), 32'd0);
        checkVal("gap done cwe", 32'(busIf.out_CAMWriteEnable), 32'd0);

        // Seventeen misses from reset walk the victim pointer 0..15 then wrap to 0.
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 17; i++) begin
            logic [31:0] a;
            a = 32'h0001_0000 + 32'(i * 16);
            applyStimulus(mkStim(1, 1, a, 0, 0, 0, 0));
            applyStimulus(mkStim(1, 1, a, 0, 1, 0, 0));
            for (int k = 0; k < 4; k++) applyStimulus(mkStim(1, 1, a, 0, 0, 1, 32'(k)));
            applyStimulus(mkStim(1, 1, a, 0, 0, 0, 0));
            checkVal($sformatf("rr%0d cwe", i), 32'(busIf.out_CAMWriteEnable), 32'd1);
            checkVal($sformatf("rr%0d cEntry", i), 32'(busIf.out_CAMWriteEntry), 32'(i % 16));
            applyStimulus(mkStim(1, 1, a, 1, 0, 0, 0));
        end

        // Reset during beat 2 of a fill into entry 1; stale beats afterwards must be dropped.
        applyStimulus(mkStim(1, 1, 32'h0000_2000, 0, 0, 0, 0));
        applyStimulus(mkStim(1, 1, 32'h0000_2000, 0, 1, 0, 0));
        applyStimulus(mkStim(1, 1, 32'h0000_2000, 0, 0, 1, 32'hC0));
        checkVal("abort beat0 dwe", 32'(busIf.out_DataWriteEnable), 32'd1);
        checkVal("abort beat0 dEntry", 32'(busIf.out_DataWriteEntry), 32'd1);
        applyStimulus(mkStim(1, 1, 32'h0000_2000, 0, 0, 1, 32'hC1));
        applyStimulus(mkStim(0, 1, 32'h0000_2000, 0, 0, 1, 32'hC2));
        checkVal("abort reset dwe", 32'(busIf.out_DataWriteEnable), 32'd0);
        checkVal("abort reset stall", 32'(busIf.out_Stall), 32'd0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(mkStim(1, 0, 32'h0000_2000, 0, 0, 1, 32'hC3));
            checkVal($sformatf("stale%0d dwe", k), 32'(busIf.out_DataWriteEnable), 32'd0);
            checkVal($sformatf("stale%0d cwe", k), 32'(busIf.out_CAMWriteEnable), 32'd0);
            checkVal($sformatf("stale%0d stall", k), 32'(busIf.out_Stall), 32'd0);
            checkVal($sformatf("stale%0d cEntry", k), 32'(busIf.out_CAMWriteEntry), 32'd0);
        end
        applyStimulus(mkStim(1, 1, 32'h0000_3004, 0, 0, 0, 0));
        checkVal("post-abort miss stall", 32'(busIf.out_Stall), 32'd1);
        applyStimulus(mkStim(1, 1, 32'h0000_3004, 0, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkStim(1, 1, 32'h0000_3004, 0, 0, 1, 32'hD0 + 32'(k)));
            checkVal($sformatf("post-abort beat%0d dEntry", k), 32'(busIf.out_DataWriteEntry), 32'd0);
        end
        applyStimulus(mkStim(1, 1, 32'h0000_3004, 0, 0, 0, 0));
        checkVal("post-abort cwe", 32'(busIf.out_CAMWriteEnable), 32'd1);
        checkVal("post-abort cEntry", 32'(busIf.out_CAMWriteEntry), 32'd0);
        checkVal("post-abort camIn", 32'(busIf.out_CAMInput), 32'h000_0300);
        applyStimulus(mkStim(1, 0, 32'h0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cam_line_fill_ctrl.md
Name: cam_line_fill_ctrl

Overview:
Miss-side writer for the data-cache tag CAM. On a lookup miss it requests a line from memory, streams the returned words into the data array, then writes the tag into the victim CAM entry. Victim selection is round-robin. Sits between the load/store unit, the tag CAM (compare/write port) and the external memory bus.

Parameters:
AddrWidth, 32, full byte address width
WordSelWidth, 2, word-in-line select bits (4 words/line)
ByteSelWidth, 2, byte-in-word select bits
EntryNumWidth, 4, CAM entry index width (16 entries)
TagWidth, AddrWidth-WordSelWidth-ByteSelWidth (28), stored tag width = CAM entry width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
in_ReqValid  in  1  lookup request present
in_ReqAddr  in  AddrWidth  request byte address
in_CAMMatchUp  in  1  CAM hit for current in_ReqAddr tag (combinational from CAM)
out_CAMInput  out  TagWidth  tag to CAM, = in_ReqAddr[AddrWidth-1:WordSelWidth+ByteSelWidth] when idle, latched tag during fill
out_CAMWriteEntry  out  EntryNumWidth  victim entry index
out_CAMWriteEnable  out  1  one-cycle CAM tag write strobe
out_Stall  out  1  pipeline hold while miss serviced
out_MemReq  out  1  line read request to memory
out_MemAddr  out  AddrWidth  line-aligned (or critical-word) start address
in_MemAck  in  1  memory accepted request
in_MemDataValid  in  1  one data beat valid
in_MemData  in  32  returned word
out_DataWriteEnable  out  1  data array word write strobe
out_DataWriteEntry  out  EntryNumWidth  data array line index
out_DataWriteWord  out  WordSelWidth  word index within line
out_DataWriteData  out  32  word to data array

Behaviour:
- Reset (reset==0 at clock edge): state IDLE, victim pointer 0, beat counter 0; all out_* strobes/flags 0, out_MemAddr 0, out_CAMWriteEntry 0.
- IDLE: out_CAMWriteEnable=0 so CAM compares. in_ReqValid && !in_CAMMatchUp -> latch tag and word index, out_Stall=1 combinationally same cycle, next FILL_REQ. Hit or no request: stay IDLE, out_Stall=0.
- FILL_REQ: out_MemReq=1, out_MemAddr = {tag, start word, 2'b00}; held until in_MemAck; then next FILL_BEAT, counter=0.
- FILL_BEAT: each in_MemDataValid cycle -> out_DataWriteEnable=1, out_DataWriteEntry=victim, out_DataWriteWord=(start word + counter) mod 4, data passed through same cycle; counter++. Cycles without valid: no write, no advance. After 4th beat -> CAM_WRITE.
- CAM_WRITE: one cycle out_CAMWriteEnable=1, out_CAMWriteEntry=victim, out_CAMInput=latched tag; victim pointer increments, wraps 15->0. Next DONE.
- DONE: one cycle, out_Stall=0 released, returns IDLE; request re-presented and must now hit.
- Tag written only after all data beats: a partial line is never visible as a hit.
- in_MemDataValid outside FILL_BEAT ignored. in_MemAck outside FILL_REQ ignored.
- in_ReqAddr changes during fill ignored (tag latched).
- reset low mid-fill: abort immediately, no CAM write, pointer 0; outstanding memory beats after reset ignored.
- Stall latency on miss: 0 cycles; min miss penalty = 1 (REQ) + 4 beats + CAM_WRITE + DONE = 7 cycles with immediate ack.

Optional Feature:
CAM_FILL_CRITICAL_WORD_FIRST_EN: defined -> start word = requested word, out_MemAddr word bits = requested word, beats wrap mod 4. Undefined -> start word always 0, out_MemAddr word bits 0, beats in order 0..3.

Decomposition:
- Shared package: AddrWidth/WordSelWidth/ByteSelWidth/EntryNumWidth/TagWidth defines, FSM state encodings (IDLE, FILL_REQ, FILL_BEAT, CAM_WRITE, DONE), words-per-line constant.
- One sub-module: cam_victim_ptr (round-robin counter, advance strobe, wrap at 2^EntryNumWidth).

Test Plan:
- Hit: in_ReqValid=1, in_ReqAddr=0x0000_1234, in_CAMMatchUp=1 -> out_Stall=0, no out_MemReq, no CAM write.
- Miss after reset: addr 0x0000_1238, ack 2 cycles late, 4 valid beats 0xA0..0xA3 -> data writes entry 0 words 0..3 (feature off) or 2,3,0,1 (feature on); then CAM write entry 0 tag 0x0000123; out_MemAddr 0x0000_1230 (off) / 0x0000_1238 (on).
- Gapped beats: valid pattern 1,0,0,1,1,0,1 -> exactly 4 data writes, CAM write the cycle after the last beat.
- 17 consecutive misses -> CAM write entries 0,1,...,15,0.
- Reset low during beat 2 -> no CAM write, stall drops, next miss uses entry 0, stale beats produce no data write.
- Request held, addr changed mid-fill -> CAM tag equals originally latched tag.
